// File: rtl/ysyx_25060170_ifetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request, single-entry output buffer, redirect flush.
// Latency: REQ(gnt) -> WAIT(rvalid) -> HOLD, so at best one instruction every 3 cycles; HOLD stalls until out_ready.
module ysyx_25060170_ifetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    input  logic        out_ready
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        discard_q, discard_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_inst_q, out_inst_d;
    logic [31:0] redir_tgt;
    logic [1:0]  redirect_pc_lsb_unused;

    assign redir_tgt              = {redirect_pc[31:2], 2'b00};
    assign redirect_pc_lsb_unused = redirect_pc[1:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            pc_q       <= {RESET_PC[31:2], 2'b00};
            discard_q  <= 1'b0;
            out_pc_q   <= '0;
            out_inst_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            discard_q  <= discard_d;
            out_pc_q   <= out_pc_d;
            out_inst_q <= out_inst_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        discard_d  = discard_q;
        out_pc_d   = out_pc_q;
        out_inst_d = out_inst_q;
        case (state_q)
            IDLE: begin
                state_d = REQ;
                if (redirect_en) pc_d = redir_tgt;
            end
            REQ: begin
                if (redirect_en) pc_d = redir_tgt;
                if (imem_gnt) begin
                    state_d   = WAIT;
                    // The granted fetch targets the old pc; its data must be dropped.
                    discard_d = redirect_en;
                end
            end
            WAIT: begin
                if (redirect_en) begin
                    pc_d = redir_tgt;
                    if (imem_rvalid) begin
                        state_d   = REQ;
                        discard_d = 1'b0;
                    end else begin
                        discard_d = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    if (discard_q) begin
                        state_d   = REQ;
                        discard_d = 1'b0;
                    end else begin
                        state_d    = HOLD;
                        out_pc_d   = pc_q;
                        out_inst_d = imem_rdata;
                    end
                end
            end
            HOLD: begin
                if (redirect_en) begin
                    state_d = REQ;
                    pc_d    = redir_tgt;
                end else if (out_ready) begin
                    state_d = REQ;
                    pc_d    = pc_q + 32'd4;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign imem_req  = (state_q == REQ);
    assign imem_addr = (state_q == REQ) ? pc_q : '0;
    assign out_valid = (state_q == HOLD);
    assign out_pc    = out_pc_q;
    assign out_inst  = out_inst_q;

endmodule

// File: tb/tb_ysyx_25060170_ifetch_ctrl.sv
// Bench for the fetch controller: transaction-level model compared every cycle, directed scenarios, random traffic.
module tb_ysyx_25060170_ifetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] DEAD   = 32'hDEAD_BEEF;
    localparam logic [31:0] KEY    = 32'h1357_9BDF;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_ready;

    int checks   = 0;
    int failures = 0;
    int dead_seen = 0;
    bit chk_en   = 1'b0;
    bit dead_mon = 1'b0;

    ysyx_25060170_ifetch_ctrl #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .out_valid   (out_valid),
        .out_pc      (out_pc),
        .out_inst    (out_inst),
        .out_ready   (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Transaction-level model: is the fetcher idle after reset, waiting on a granted fetch
    // (whose data may be stale), or holding a buffered instruction; otherwise it is requesting.
    bit          m_idle, m_pending, m_stale, m_buf_vld;
    logic [31:0] m_pc, m_buf_pc, m_buf_inst;

    always @(posedge clk) begin
        logic [31:0] tgt;
        tgt = redirect_pc & ~32'd3;
        if (!rst) begin
            m_idle = 1; m_pending = 0; m_stale = 0; m_buf_vld = 0;
            m_pc = RST_PC; m_buf_pc = 0; m_buf_inst = 0;
        end else if (m_idle) begin
            m_idle = 0;
            if (redirect_en) m_pc = tgt;
        end else if (m_buf_vld) begin
            if (redirect_en) begin
                m_buf_vld = 0; m_pc = tgt;
            end else if (out_ready) begin
                m_buf_vld = 0; m_pc = m_pc + 32'd4;
            end
        end else if (m_pending) begin
            if (redirect_en) begin
                m_pc = tgt;
                if (imem_rvalid) begin m_pending = 0; m_stale = 0; end
                else m_stale = 1;
            end else if (imem_rvalid) begin
                m_pending = 0;
                if (m_stale) m_stale = 0;
                else begin m_buf_vld = 1; m_buf_pc = m_pc; m_buf_inst = imem_rdata; end
            end
        end else begin
            if (imem_gnt) begin
                m_pending = 1;
                if (redirect_en) begin m_pc = tgt; m_stale = 1; end
            end else if (redirect_en) begin
                m_pc = tgt;
            end
        end
    end

    always @(negedge clk) begin
        bit e_req;
        if (chk_en) begin
            e_req = !m_idle && !m_pending && !m_buf_vld;
            check("m_imem_req",  {31'd0, imem_req},  {31'd0, e_req});
            check("m_imem_addr", imem_addr, e_req ? m_pc : 32'd0);
            check("m_out_valid", {31'd0, out_valid}, {31'd0, m_buf_vld});
            check("m_out_pc",    out_pc,   m_buf_pc);
            check("m_out_inst",  out_inst, m_buf_inst);
            if (dead_mon && out_valid && out_inst == DEAD) dead_seen++;
        end
    end

    task automatic cyc(input logic g, input logic rv, input logic [31:0] rd,
                       input logic re, input logic [31:0] rp, input logic rdy, input logic r);
        imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
        redirect_en = re; redirect_pc = rp; out_ready = rdy; rst = r;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic        last_gr;
        logic [31:0] last_addr;
        logic [31:0] v_pc[$];
        logic [31:0] v_inst[$];
        int          v_cyc[$];

        rst = 0; imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
        redirect_en = 0; redirect_pc = 0; out_ready = 0;
        @(negedge clk);
        @(negedge clk);
        chk_en = 1; dead_mon = 1;
        check("rst_req",   {31'd0, imem_req},  32'd0);
        check("rst_addr",  imem_addr, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_outpc", out_pc, 32'd0);
        check("rst_inst",  out_inst, 32'd0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        check("first_req",  {31'd0, imem_req}, 32'd1);
        check("first_addr", imem_addr, RST_PC);

        // Streaming: grant always, data one cycle after grant, decode always ready.
        last_gr = 0; last_addr = 0;
        for (int i = 0; i < 9; i++) begin
            logic rv;
            logic [31:0] rd;
            if (out_valid) begin v_pc.push_back(out_pc); v_inst.push_back(out_inst); v_cyc.push_back(i); end
            rv = last_gr; rd = last_addr ^ KEY;
            last_gr = imem_req; last_addr = imem_addr;
            cyc(1, rv, rd, 0, 0, 1, 1);
        end
        check("stream_count", v_pc.size(), 3);
        if (v_pc.size() == 3) begin
            for (int k = 0; k < 3; k++) begin
                check("stream_pc",   v_pc[k], RST_PC + 32'(4 * k));
                check("stream_inst", v_inst[k], (RST_PC + 32'(4 * k)) ^ KEY);
                check("stream_cyc",  v_cyc[k], 2 + 3 * k);
            end
        end

        // Decode stall in HOLD.
        cyc(1, 0, 0, 0, 0, 0, 1);
        cyc(0, 1, 32'h1111_2222, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_pc",    out_pc, 32'h8000_000C);
            check("stall_inst",  out_inst, 32'h1111_2222);
            check("stall_req",   {31'd0, imem_req}, 32'd0);
            cyc(0, 0, 0, 0, 0, 0, 1);
        end
        check("stall_valid5", {31'd0, out_valid}, 32'd1);
        cyc(0, 0, 0, 0, 0, 1, 1);
        check("stall_next", imem_addr, 32'h8000_0010);

        // Redirect coinciding with grant.
        cyc(1, 0, 0, 1, 32'h8000_0040, 0, 1);
        check("rg_wait_req", {31'd0, imem_req}, 32'd0);
        cyc(0, 1, DEAD, 0, 0, 1, 1);
        check("rg_addr",  imem_addr, 32'h8000_0040);
        check("rg_valid", {31'd0, out_valid}, 32'd0);

        // Redirect while waiting, unaligned target.
        cyc(1, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 32'h8000_0103, 0, 1);
        check("rw_req", {31'd0, imem_req}, 32'd0);
        cyc(0, 1, DEAD, 0, 0, 1, 1);
        check("rw_addr",  imem_addr, 32'h8000_0100);
        check("rw_valid", {31'd0, out_valid}, 32'd0);

        // Redirect in HOLD (with ready) and pc wrap.
        cyc(1, 0, 0, 0, 0, 0, 1);
        cyc(0, 1, 32'h3333_4444, 0, 0, 0, 1);
        check("rh_pc", out_pc, 32'h8000_0100);
        cyc(0, 0, 0, 1, 32'hFFFF_FFFE, 1, 1);
        check("rh_valid", {31'd0, out_valid}, 32'd0);
        check("rh_addr",  imem_addr, 32'hFFFF_FFFC);
        cyc(1, 0, 0, 0, 0, 0, 1);
        cyc(0, 1, 32'h5555_6666, 0, 0, 0, 1);
        check("wrap_pc", out_pc, 32'hFFFF_FFFC);
        cyc(0, 0, 0, 0, 0, 1, 1);
        check("wrap_addr", imem_addr, 32'h0000_0000);
        check("wrap_req",  {31'd0, imem_req}, 32'd1);

        // Reset with a request in flight; late rvalid ignored.
        cyc(1, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check("mr_req",   {31'd0, imem_req}, 32'd0);
        check("mr_addr",  imem_addr, 32'd0);
        check("mr_outpc", out_pc, 32'd0);
        cyc(0, 1, DEAD, 0, 0, 0, 1);
        check("mr_req2",  {31'd0, imem_req}, 32'd1);
        check("mr_addr2", imem_addr, RST_PC);
        check("mr_valid", {31'd0, out_valid}, 32'd0);
        check("never_dead", dead_seen, 0);
        dead_mon = 0;

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom % 2), 1'($urandom % 3 == 0), $urandom,
                1'($urandom % 8 == 0), $urandom, 1'($urandom % 2),
                1'($urandom % 97 != 0));
        end

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_25060170_ifetch_ctrl.md
YSYX_25060170_IFETCH_CTRL -- requirements
Module: ysyx_25060170_ifetch_ctrl

Interface
REQ-001 Parameter: RESET_PC, 32'h8000_0000, PC value loaded on reset.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-low reset (rst==0 at a rising edge resets the block).
REQ-004 Port: redirect_en  input  1  jump/branch redirect request from execute stage.
REQ-005 Port: redirect_pc  input  32  redirect target; bits [1:0] ignored.
REQ-006 Port: imem_req  output  1  instruction memory request valid.
REQ-007 Port: imem_addr  output  32  instruction memory request address.
REQ-008 Port: imem_gnt  input  1  memory accepts request this cycle (qualified by imem_req).
REQ-009 Port: imem_rvalid  input  1  read data valid.
REQ-010 Port: imem_rdata  input  32  read data.
REQ-011 Port: out_valid  output  1  fetched instruction available to decode.
REQ-012 Port: out_pc  output  32  PC of presented instruction.
REQ-013 Port: out_inst  output  32  presented instruction.
REQ-014 Port: out_ready  input  1  decode accepts instruction.

Function
REQ-015 FSM states SHALL be IDLE, REQ, WAIT, HOLD; one outstanding memory request maximum.
REQ-016 Internal pc register SHALL be 32 bits with pc[1:0] always 0; sequential next = pc+4, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-017 IDLE: all outputs deasserted; unconditional transition to REQ next cycle.
REQ-018 REQ: imem_req=1, imem_addr=pc; imem_gnt=1 -> WAIT; else stay REQ with imem_addr unchanged.
REQ-019 WAIT: imem_req=0; imem_rvalid=1 with discard flag clear -> capture {pc, imem_rdata} into output buffer, go HOLD.
REQ-020 WAIT: imem_rvalid=1 with discard flag set -> drop data, clear discard flag, go REQ.
REQ-021 HOLD: out_valid=1, out_pc/out_inst stable until handshake; out_ready=1 -> pc<=pc+4, go REQ.
REQ-022 imem_rvalid outside WAIT SHALL be ignored with no state change.
REQ-023 Redirect in IDLE or REQ without grant: pc<=redirect_pc & ~3, next state REQ; new address on imem_addr next cycle.
REQ-024 Redirect in REQ coinciding with imem_gnt: pc<=redirect target, set discard flag, go WAIT.
REQ-025 Redirect in WAIT: pc<=redirect target, set discard flag, stay WAIT; if imem_rvalid same cycle, drop that data, leave discard flag clear, go REQ.
REQ-026 Redirect in HOLD: buffered instruction flushed (whether or not out_ready=1), out_valid=0 next cycle, pc<=redirect target, go REQ.
REQ-027 Redirect SHALL take priority over sequential pc+4 update in every state.
REQ-028 out_valid SHALL be asserted only in HOLD; out_pc/out_inst hold last captured values otherwise.
REQ-029 Best-case throughput: one instruction per 3 cycles (REQ gnt, WAIT rvalid, HOLD ready).
REQ-030 A redirected fetch SHALL never present the stale instruction on out_valid.

Reset
REQ-031 rst==0 at rising edge: state<=IDLE, pc<=RESET_PC, discard flag<=0, out_pc<=0, out_inst<=0.
REQ-032 During and the cycle after reset: imem_req=0, out_valid=0, imem_addr=0.
REQ-033 Reset mid-operation (any state, incl. WAIT with request in flight) SHALL abandon all state; a late imem_rvalid after reset SHALL be ignored (state not WAIT).
REQ-034 First imem_req=1 with imem_addr=RESET_PC SHALL occur the second cycle after rst returns to 1.

Verification
REQ-035 Reset release, gnt=1 always, rvalid one cycle after gnt, out_ready=1 -> out_pc sequence 0x8000_0000, 0x8000_0004, 0x8000_0008 each with matching imem_rdata, one out_valid per 3 cycles.
REQ-036 out_ready=0 for 5 cycles in HOLD -> out_valid, out_pc, out_inst constant; no imem_req; pc advances only after out_ready=1.
REQ-037 Redirect to 0x8000_0103 while in WAIT, then rvalid with 0xDEAD_BEEF -> data dropped, next imem_addr=0x8000_0100, out_valid never shows 0xDEAD_BEEF.
REQ-038 Redirect same cycle as imem_gnt at 0x8000_0010 -> WAIT, returned data dropped, next request at redirect target.
REQ-039 Redirect in HOLD with out_ready=1 -> out_valid=0 next cycle, next imem_addr=redirect target; pc+4 not applied.
REQ-040 Redirect to 0xFFFF_FFFC then accept -> next imem_addr=0x0000_0000; rst=0 asserted in WAIT -> IDLE, imem_addr=RESET_PC two cycles after release.
